// File: rtl/rt_pkg.sv
// Shared ray-tracer types and fixed-point constants (Q8.24, 3-bit object index).
package rt_pkg;

    localparam int FIX_W  = 32;
    localparam int VEC3_W = 96;
    localparam int OBJ_W  = 3;

    localparam logic [FIX_W-1:0] FIX_ONE  = 32'd16777216;
    localparam logic [FIX_W-1:0] T_FAR    = 32'hFFFF_FFFF;
    localparam logic [OBJ_W-1:0] OBJ_NONE = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } scan_state_t;

endpackage

// File: rtl/nearest_hit_reg.sv
// Running nearest-hit record for one ray: cleared on init, replaced by a closer valid hit.
module nearest_hit_reg
    import rt_pkg::*;
#(
    parameter logic [FIX_W-1:0] T_EPS = 32'h0001_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_init,
    input  logic             i_upd,
    input  logic             i_hit,
    input  logic [FIX_W-1:0] i_t,
    input  logic [OBJ_W-1:0] i_obj,
    input  logic [OBJ_W-1:0] i_mat,
    output logic             o_hit,
    output logic [OBJ_W-1:0] o_obj,
    output logic [OBJ_W-1:0] o_mat,
    output logic [FIX_W-1:0] o_t
);

    logic             r_hit;
    logic [OBJ_W-1:0] r_obj;
    logic [OBJ_W-1:0] r_mat;
    logic [FIX_W-1:0] r_t;
    logic             w_take;

    // Strict less-than keeps the earlier (lower index) object on a tie.
    assign w_take = i_upd && i_hit && (i_t >= T_EPS) && (i_t < r_t);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit <= 1'b0;
            r_obj <= OBJ_NONE;
            r_mat <= OBJ_NONE;
            r_t   <= T_FAR;
        end else if (i_init) begin
            r_hit <= 1'b0;
            r_obj <= OBJ_NONE;
            r_mat <= OBJ_NONE;
            r_t   <= T_FAR;
        end else if (w_take) begin
            r_hit <= 1'b1;
            r_obj <= i_obj;
            r_mat <= i_mat;
            r_t   <= i_t;
        end
    end

    assign o_hit = r_hit;
    assign o_obj = r_obj;
    assign o_mat = r_mat;
    assign o_t   = r_t;

endmodule

// File: rtl/sphere_scan_ctrl.sv
// Scans the sphere table for one ray at a time and returns the nearest valid hit.
module sphere_scan_ctrl
    import rt_pkg::*;
#(
    parameter int               NUM_SPHERES = 3,
    parameter logic [FIX_W-1:0] T_EPS       = 32'h0001_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [VEC3_W-1:0] ray_orig,
    input  logic [VEC3_W-1:0] ray_dir,
    output logic [OBJ_W-1:0]  obj_id,
    input  logic [OBJ_W-1:0]  tbl_mat_id,
    output logic [VEC3_W-1:0] isect_orig,
    output logic [VEC3_W-1:0] isect_dir,
    output logic              isect_req_valid,
    input  logic              isect_req_ready,
    input  logic              isect_res_valid,
    input  logic              isect_hit,
    input  logic [FIX_W-1:0]  isect_t,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_hit,
    output logic [OBJ_W-1:0]  res_obj_id,
    output logic [OBJ_W-1:0]  res_mat_id,
    output logic [FIX_W-1:0]  res_t
);

    localparam logic [OBJ_W-1:0] LAST_IDX = OBJ_W'(NUM_SPHERES - 1);

    scan_state_t       r_state;
    logic [OBJ_W-1:0]  r_idx;
    logic [VEC3_W-1:0] r_orig;
    logic [VEC3_W-1:0] r_dir;
    logic              r_res_valid;
    logic              r_res_hit;
    logic [OBJ_W-1:0]  r_res_obj;
    logic [OBJ_W-1:0]  r_res_mat;
    logic [FIX_W-1:0]  r_res_t;

    logic              w_accept;
    logic              w_result;
    logic              w_best_hit;
    logic [OBJ_W-1:0]  w_best_obj;
    logic [OBJ_W-1:0]  w_best_mat;
    logic [FIX_W-1:0]  w_best_t;

    assign w_accept = (r_state == ST_IDLE) && req_valid;
    assign w_result = (r_state == ST_WAIT) && isect_res_valid;

    nearest_hit_reg #(
        .T_EPS (T_EPS)
    ) u_best (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_init (w_accept),
        .i_upd  (w_result),
        .i_hit  (isect_hit),
        .i_t    (isect_t),
        .i_obj  (r_idx),
        .i_mat  (tbl_mat_id),
        .o_hit  (w_best_hit),
        .o_obj  (w_best_obj),
        .o_mat  (w_best_mat),
        .o_t    (w_best_t)
    );

    // The last result lands in the best record on the DONE entry edge, so DONE
    // spends its first cycle copying it into the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_orig      <= '0;
            r_dir       <= '0;
            r_res_valid <= 1'b0;
            r_res_hit   <= 1'b0;
            r_res_obj   <= OBJ_NONE;
            r_res_mat   <= OBJ_NONE;
            r_res_t     <= T_FAR;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_orig  <= ray_orig;
                        r_dir   <= ray_dir;
                        r_idx   <= '0;
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: r_state <= ST_ISSUE;
                ST_ISSUE: begin
                    if (isect_req_ready) r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (isect_res_valid) begin
                        if (r_idx == LAST_IDX) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    if (!r_res_valid) begin
                        r_res_valid <= 1'b1;
                        r_res_hit   <= w_best_hit;
                        r_res_obj   <= w_best_obj;
                        r_res_mat   <= w_best_mat;
                        r_res_t     <= w_best_t;
                    end else if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready       = (r_state == ST_IDLE);
    assign isect_req_valid = (r_state == ST_ISSUE);
    assign obj_id          = r_idx;
    assign isect_orig      = r_orig;
    assign isect_dir       = r_dir;
    assign res_valid       = r_res_valid;
    assign res_hit         = r_res_hit;
    assign res_obj_id      = r_res_obj;
    assign res_mat_id      = r_res_mat;
    assign res_t           = r_res_t;

endmodule

// File: tb/tb_sphere_scan_ctrl.sv
// Directed bench for sphere_scan_ctrl with a one-cycle table model and a scripted intersection unit.
module tb_sphere_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [95:0] ray_orig = '0;
    logic [95:0] ray_dir = '0;
    logic [2:0]  obj_id;
    logic [2:0]  tbl_mat_id = 3'd0;
    logic [95:0] isect_orig;
    logic [95:0] isect_dir;
    logic        isect_req_valid;
    logic        isect_req_ready = 1'b1;
    logic        isect_res_valid = 1'b0;
    logic        isect_hit = 1'b0;
    logic [31:0] isect_t = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        res_hit;
    logic [2:0]  res_obj_id;
    logic [2:0]  res_mat_id;
    logic [31:0] res_t;

    int n_tests = 0;
    int n_fail  = 0;

    sphere_scan_ctrl #(
        .NUM_SPHERES (3),
        .T_EPS       (32'h0001_0000)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .ray_orig        (ray_orig),
        .ray_dir         (ray_dir),
        .obj_id          (obj_id),
        .tbl_mat_id      (tbl_mat_id),
        .isect_orig      (isect_orig),
        .isect_dir       (isect_dir),
        .isect_req_valid (isect_req_valid),
        .isect_req_ready (isect_req_ready),
        .isect_res_valid (isect_res_valid),
        .isect_hit       (isect_hit),
        .isect_t         (isect_t),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_hit         (res_hit),
        .res_obj_id      (res_obj_id),
        .res_mat_id      (res_mat_id),
        .res_t           (res_t)
    );

    always #5 clk = ~clk;

    // Sphere table: mat_id equals the object index, one clock after obj_id.
    always @(posedge clk) tbl_mat_id <= obj_id;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".req_ready"},  96'(req_ready), 96'(1'b1));
        chk({tag, ".isect_vld"},  96'(isect_req_valid), 96'(1'b0));
        chk({tag, ".res_valid"},  96'(res_valid), 96'(1'b0));
        chk({tag, ".obj_id"},     96'(obj_id), 96'(3'd0));
        chk({tag, ".res_hit"},    96'(res_hit), 96'(1'b0));
        chk({tag, ".res_obj"},    96'(res_obj_id), 96'(3'd7));
        chk({tag, ".res_mat"},    96'(res_mat_id), 96'(3'd7));
        chk({tag, ".res_t"},      96'(res_t), 96'(32'hFFFF_FFFF));
        chk({tag, ".isect_orig"}, isect_orig, 96'd0);
        chk({tag, ".isect_dir"},  isect_dir, 96'd0);
    endtask

    // One ray through three spheres; leaves res_ready=1 so the next negedge follows the handshake.
    task automatic do_ray(input string tag, input logic [95:0] org, input logic [95:0] dir,
                          input logic [2:0] hits, input logic [31:0] t0, input logic [31:0] t1,
                          input logic [31:0] t2, input int issue_stall, input int res_stall,
                          input bit spur, input logic exp_hit, input logic [2:0] exp_obj,
                          input logic [31:0] exp_t);
        logic [31:0] tv [3];
        int n;
        tv[0] = t0; tv[1] = t1; tv[2] = t2;
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, ".req_ready"}, 96'(req_ready), 96'(1'b1));
        ray_orig  = org;
        ray_dir   = dir;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        ray_orig  = '0;
        ray_dir   = '0;
        n = 0;
        chk({tag, ".isect_orig"}, isect_orig, org);
        chk({tag, ".isect_dir"},  isect_dir, dir);
        for (int s = 0; s < 3; s++) begin
            chk({tag, ".fetch_obj"}, 96'(obj_id), 96'(s));
            chk({tag, ".fetch_vld"}, 96'(isect_req_valid), 96'(1'b0));
            chk({tag, ".busy_rdy"},  96'(req_ready), 96'(1'b0));
            if (spur && s == 1) begin
                isect_res_valid = 1'b1;
                isect_hit       = 1'b1;
                isect_t         = 32'h0010_0000;
            end
            @(negedge clk); n++;
            isect_res_valid = 1'b0;
            isect_hit       = 1'b0;
            if (issue_stall > 0 && s == 0) begin
                isect_req_ready = 1'b0;
                for (int k = 0; k < issue_stall; k++) begin
                    chk({tag, ".stall_vld"}, 96'(isect_req_valid), 96'(1'b1));
                    chk({tag, ".stall_obj"}, 96'(obj_id), 96'(s));
                    chk({tag, ".stall_rdy"}, 96'(req_ready), 96'(1'b0));
                    @(negedge clk); n++;
                end
                isect_req_ready = 1'b1;
            end
            chk({tag, ".issue_vld"}, 96'(isect_req_valid), 96'(1'b1));
            @(negedge clk); n++;
            chk({tag, ".wait_vld"}, 96'(isect_req_valid), 96'(1'b0));
            isect_res_valid = 1'b1;
            isect_hit       = hits[s];
            isect_t         = tv[s];
            @(negedge clk); n++;
            isect_res_valid = 1'b0;
            isect_hit       = 1'b0;
            isect_t         = '0;
        end
        for (int k = 0; k < 8 && !res_valid; k++) begin
            @(negedge clk); n++;
        end
        chk({tag, ".res_valid"}, 96'(res_valid), 96'(1'b1));
        if (issue_stall == 0) chk({tag, ".latency"}, 96'(n), 96'(10));
        chk({tag, ".res_hit"}, 96'(res_hit), 96'(exp_hit));
        chk({tag, ".res_obj"}, 96'(res_obj_id), 96'(exp_obj));
        chk({tag, ".res_mat"}, 96'(res_mat_id), 96'(exp_obj));
        chk({tag, ".res_t"},   96'(res_t), 96'(exp_t));
        for (int k = 0; k < res_stall; k++) begin
            @(negedge clk);
            chk({tag, ".hold_vld"}, 96'(res_valid), 96'(1'b1));
            chk({tag, ".hold_obj"}, 96'(res_obj_id), 96'(exp_obj));
            chk({tag, ".hold_t"},   96'(res_t), 96'(exp_t));
            chk({tag, ".hold_rdy"}, 96'(req_ready), 96'(1'b0));
            chk({tag, ".hold_oid"}, 96'(obj_id), 96'(3'd2));
        end
        res_ready = 1'b1;
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;

        do_ray("nearest", {32'd3, 32'd2, 32'd1}, {32'd0, 32'd0, 32'h0100_0000},
               3'b101, 32'h0300_0000, 32'h0040_0000, 32'h0180_0000,
               0, 0, 1'b0, 1'b1, 3'd2, 32'h0180_0000);
        do_ray("tie", {32'd6, 32'd5, 32'd4}, {32'd0, 32'h0100_0000, 32'd0},
               3'b011, 32'h0200_0000, 32'h0200_0000, 32'h0040_0000,
               0, 0, 1'b0, 1'b1, 3'd0, 32'h0200_0000);
        do_ray("miss", {32'd9, 32'd8, 32'd7}, {32'h0100_0000, 32'd0, 32'd0},
               3'b010, 32'h0040_0000, 32'h0000_0100, 32'h0040_0000,
               0, 0, 1'b0, 1'b0, 3'd7, 32'hFFFF_FFFF);
        do_ray("stall", {32'hA, 32'hB, 32'hC}, {32'h1, 32'h2, 32'h3},
               3'b110, 32'h0040_0000, 32'h0500_0000, 32'h0280_0000,
               4, 5, 1'b0, 1'b1, 3'd2, 32'h0280_0000);

        // Abort a ray while it waits on obj1.
        @(negedge clk);
        res_ready = 1'b0;
        ray_orig  = {32'h11, 32'h22, 32'h33};
        ray_dir   = {32'h44, 32'h55, 32'h66};
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        isect_res_valid = 1'b1;
        isect_hit       = 1'b1;
        isect_t         = 32'h0100_0000;
        @(negedge clk);
        isect_res_valid = 1'b0;
        isect_hit       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort.pre_obj", 96'(obj_id), 96'(3'd1));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort.no_result", 96'(res_valid), 96'(1'b0));

        do_ray("after_rst", {32'h1, 32'h1, 32'h1}, {32'h2, 32'h2, 32'h2},
               3'b010, 32'h0040_0000, 32'h0001_0000, 32'h0040_0000,
               0, 0, 1'b0, 1'b1, 3'd1, 32'h0001_0000);
        do_ray("b2b_spur", {32'h7, 32'h7, 32'h7}, {32'h8, 32'h8, 32'h8},
               3'b100, 32'h0040_0000, 32'h0040_0000, 32'h0700_0000,
               0, 0, 1'b1, 1'b1, 3'd2, 32'h0700_0000);
        do_ray("b2b_second", {32'h9, 32'h9, 32'h9}, {32'hA, 32'hA, 32'hA},
               3'b111, 32'h0300_0000, 32'h0200_0000, 32'h0200_0000,
               0, 0, 1'b0, 1'b1, 3'd1, 32'h0200_0000);

        @(negedge clk);
        res_ready = 1'b0;
        chk("end.req_ready", 96'(req_ready), 96'(1'b1));
        chk("end.res_valid", 96'(res_valid), 96'(1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
